// File: rtl/branch_hazard_pkg.sv
// Shared types and constants for the branch hazard controller.
//   state_t            : FSM states (S_IDLE, S_STALL)
//   STALL_FWD_IDEX     : stall depth for an ID/EX producer when forwarding is on
//   STALL_NOFWD_IDEX   : stall depth for an ID/EX producer with no forwarding
//   STALL_NOFWD_EXMEM  : stall depth for an EX/MEM producer with no forwarding
package branch_hazard_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam int STALL_FWD_IDEX    = 1;
    localparam int STALL_NOFWD_IDEX  = 2;
    localparam int STALL_NOFWD_EXMEM = 1;

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF.
// Ports:
//   clk_i    : clock
//   clr_i    : synchronous clear, active-high
//   en_i     : count enable (one increment per cycle)
//   count_o  : current count
module sat_counter16 (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= 16'h0000;
        end else if (en_i && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Stall/flush controller for branches resolved in ID. Holds PC and IF/ID and
// bubbles ID/EX while a branch operand producer is still too young to be
// forwarded (or written back), then flushes IF/ID on a taken branch.
// Optional feature macro: BRANCH_HAZARD_STATS_EN adds stall_cycles and
// taken_flushes saturating event counters.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   forwarding                      : selects forwarding (1) or no-forwarding (0) depth table
//   branch, branch_taken, kill      : ID branch, comparator result, squash
//   rs, rt                          : ID source registers
//   reg_write_idex, mem_read_idex, writebackreg_idex    : ID/EX producer info
//   reg_write_exmem, mem_read_exmem, writebackreg_exmem : EX/MEM producer info
//   stall, bubble_idex, flush_ifid  : pipeline control outputs
//   busy                            : FSM in S_STALL
//   stall_cycles, taken_flushes     : event counters (BRANCH_HAZARD_STATS_EN only)
module branch_hazard_ctrl
    import branch_hazard_pkg::*;
#(
    parameter int STALL_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       forwarding,
    input  logic       branch,
    input  logic       branch_taken,
    input  logic       kill,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       reg_write_idex,
    input  logic       mem_read_idex,
    input  logic [4:0] writebackreg_idex,
    input  logic       reg_write_exmem,
    input  logic       mem_read_exmem,
    input  logic [4:0] writebackreg_exmem,
    output logic       stall,
    output logic       bubble_idex,
    output logic       flush_ifid,
    output logic       busy
`ifdef BRANCH_HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] taken_flushes
`endif
);

    state_t               state_q, state_d;
    logic [STALL_W-1:0]   count_q, count_d;
    logic [STALL_W-1:0]   depth;
    logic                 hit_idex, hit_exmem;

    // Loads and ALU ops need the same depth here; the load flag only matters
    // to the load-use unit.
    logic unused_mem_read;
    assign unused_mem_read = mem_read_idex ^ mem_read_exmem;

    // A producer matters only if it writes a nonzero register read by the branch.
    assign hit_idex  = reg_write_idex && (writebackreg_idex != 5'd0) &&
                       ((writebackreg_idex == rs) || (writebackreg_idex == rt));
    assign hit_exmem = reg_write_exmem && (writebackreg_exmem != 5'd0) &&
                       ((writebackreg_exmem == rs) || (writebackreg_exmem == rt));

    // The ID/EX producer is always at least as deep as EX/MEM, so checking it
    // first yields the maximum over both operands.
    always_comb begin
        depth = '0;
        if (forwarding) begin
            if (hit_idex) depth = STALL_W'(STALL_FWD_IDEX);
        end else begin
            if (hit_idex)       depth = STALL_W'(STALL_NOFWD_IDEX);
            else if (hit_exmem) depth = STALL_W'(STALL_NOFWD_EXMEM);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        stall      = 1'b0;
        flush_ifid = 1'b0;
        if (kill) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (branch) begin
                        if (depth != '0) begin
                            stall   = 1'b1;
                            count_d = depth - STALL_W'(1);
                            state_d = (depth > STALL_W'(1)) ? S_STALL : S_IDLE;
                        end else begin
                            flush_ifid = branch_taken;
                        end
                    end
                end
                S_STALL: begin
                    // Hazards are not re-evaluated here; the remaining count is trusted.
                    stall = 1'b1;
                    if (count_q <= STALL_W'(1)) begin
                        count_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        count_d = count_q - STALL_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign bubble_idex = stall;
    assign busy        = (state_q == S_STALL);

`ifdef BRANCH_HAZARD_STATS_EN
    sat_counter16 u_stall_cnt (
        .clk_i   (clk),
        .clr_i   (reset),
        .en_i    (stall),
        .count_o (stall_cycles)
    );

    sat_counter16 u_flush_cnt (
        .clk_i   (clk),
        .clr_i   (reset),
        .en_i    (flush_ifid),
        .count_o (taken_flushes)
    );
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       forwarding;
    logic       branch;
    logic       branch_taken;
    logic       kill;
    logic [4:0] rs, rt;
    logic       reg_write_idex, mem_read_idex;
    logic [4:0] writebackreg_idex;
    logic       reg_write_exmem, mem_read_exmem;
    logic [4:0] writebackreg_exmem;
    logic       stall, bubble_idex, flush_ifid, busy;
`ifdef BRANCH_HAZARD_STATS_EN
    logic [15:0] stall_cycles, taken_flushes;
`endif

    int n_checks;
    int n_fail;

    branch_hazard_ctrl #(.STALL_W(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .forwarding         (forwarding),
        .branch             (branch),
        .branch_taken       (branch_taken),
        .kill               (kill),
        .rs                 (rs),
        .rt                 (rt),
        .reg_write_idex     (reg_write_idex),
        .mem_read_idex      (mem_read_idex),
        .writebackreg_idex  (writebackreg_idex),
        .reg_write_exmem    (reg_write_exmem),
        .mem_read_exmem     (mem_read_exmem),
        .writebackreg_exmem (writebackreg_exmem),
        .stall              (stall),
        .bubble_idex        (bubble_idex),
        .flush_ifid         (flush_ifid),
        .busy               (busy)
`ifdef BRANCH_HAZARD_STATS_EN
        ,
        .stall_cycles       (stall_cycles),
        .taken_flushes      (taken_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clear all producer/branch inputs to a quiet pipeline.
    task automatic quiet();
        branch             = 1'b0;
        branch_taken       = 1'b0;
        kill               = 1'b0;
        rs                 = 5'd0;
        rt                 = 5'd0;
        reg_write_idex     = 1'b0;
        mem_read_idex      = 1'b0;
        writebackreg_idex  = 5'd0;
        reg_write_exmem    = 1'b0;
        mem_read_exmem     = 1'b0;
        writebackreg_exmem = 5'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        quiet();
        forwarding = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({stall, bubble_idex, flush_ifid, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000", {stall, bubble_idex, flush_ifid, busy});
        end
    endtask

    task automatic test_fwd_alu();
        // forwarding, ALU writes $5 in ID/EX, branch rs=5, taken
        @(negedge clk);
        quiet();
        forwarding = 1'b1;
        branch = 1'b1; branch_taken = 1'b1; rs = 5'd5; rt = 5'd9;
        reg_write_idex = 1'b1; writebackreg_idex = 5'd5;
        #1;
        n_checks++;
        if ({stall, bubble_idex, flush_ifid, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL fwd_alu_stall: got %b expected 1100", {stall, bubble_idex, flush_ifid, busy});
        end
        @(negedge clk);
        reg_write_idex = 1'b0; writebackreg_idex = 5'd0;
        reg_write_exmem = 1'b1; writebackreg_exmem = 5'd5;
        #1;
        n_checks++;
        if ({stall, bubble_idex, flush_ifid, busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL fwd_alu_resolve: got %b expected 0010", {stall, bubble_idex, flush_ifid, busy});
        end
        @(negedge clk);
        quiet();
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL fwd_alu_after: got %b expected 000", {stall, flush_ifid, busy});
        end
    endtask

    task automatic test_fwd_load();
        // forwarding, lw $7 in ID/EX, branch rt=7, not taken
        @(negedge clk);
        quiet();
        forwarding = 1'b1;
        branch = 1'b1; rs = 5'd1; rt = 5'd7;
        reg_write_idex = 1'b1; mem_read_idex = 1'b1; writebackreg_idex = 5'd7;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL fwd_load_stall: got %b expected 100", {stall, flush_ifid, busy});
        end
        @(negedge clk);
        reg_write_idex = 1'b0; mem_read_idex = 1'b0; writebackreg_idex = 5'd0;
        reg_write_exmem = 1'b1; mem_read_exmem = 1'b1; writebackreg_exmem = 5'd7;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL fwd_load_resolve: got %b expected 000", {stall, flush_ifid, busy});
        end
    endtask

    task automatic test_nofwd_d2();
        // no forwarding, $3 in ID/EX, $4 in EX/MEM, branch rs=4 rt=3, taken
        @(negedge clk);
        quiet();
        forwarding = 1'b0;
        branch = 1'b1; branch_taken = 1'b1; rs = 5'd4; rt = 5'd3;
        reg_write_idex = 1'b1; writebackreg_idex = 5'd3;
        reg_write_exmem = 1'b1; writebackreg_exmem = 5'd4;
        #1;
        n_checks++;
        if ({stall, bubble_idex, flush_ifid, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL nofwd_d2_cycle1: got %b expected 1100", {stall, bubble_idex, flush_ifid, busy});
        end
        @(negedge clk);
        reg_write_idex = 1'b0; writebackreg_idex = 5'd0;
        writebackreg_exmem = 5'd3;
        #1;
        n_checks++;
        if ({stall, bubble_idex, flush_ifid, busy} !== 4'b1101) begin
            n_fail++;
            $display("FAIL nofwd_d2_cycle2: got %b expected 1101", {stall, bubble_idex, flush_ifid, busy});
        end
        @(negedge clk);
        reg_write_exmem = 1'b0; writebackreg_exmem = 5'd0;
        #1;
        n_checks++;
        if ({stall, bubble_idex, flush_ifid, busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL nofwd_d2_resolve: got %b expected 0010", {stall, bubble_idex, flush_ifid, busy});
        end
    endtask

    task automatic test_nofwd_exmem();
        // no forwarding, only EX/MEM matches: single stall cycle, never busy
        @(negedge clk);
        quiet();
        forwarding = 1'b0;
        branch = 1'b1; rs = 5'd8; rt = 5'd2;
        reg_write_exmem = 1'b1; writebackreg_exmem = 5'd8;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL nofwd_exmem_stall: got %b expected 100", {stall, flush_ifid, busy});
        end
        @(negedge clk);
        reg_write_exmem = 1'b0; writebackreg_exmem = 5'd0;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL nofwd_exmem_resolve: got %b expected 000", {stall, flush_ifid, busy});
        end
    endtask

    task automatic test_zero_and_nomatch();
        @(negedge clk);
        quiet();
        forwarding = 1'b1;
        branch = 1'b1; rs = 5'd0; rt = 5'd0;
        reg_write_idex = 1'b1; writebackreg_idex = 5'd0;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_reg: got %b expected 000", {stall, flush_ifid, busy});
        end
        @(negedge clk);
        quiet();
        forwarding = 1'b0;
        branch = 1'b1; branch_taken = 1'b1; rs = 5'd10; rt = 5'd11;
        reg_write_idex = 1'b1; writebackreg_idex = 5'd12;
        reg_write_exmem = 1'b1; writebackreg_exmem = 5'd13;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL nomatch_taken: got %b expected 010", {stall, flush_ifid, busy});
        end
        // destination matches but producer does not write: no stall
        @(negedge clk);
        branch_taken = 1'b0;
        reg_write_idex = 1'b0; writebackreg_idex = 5'd10;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL nowrite_untaken: got %b expected 000", {stall, flush_ifid, busy});
        end
        // non-branch with a hazard-shaped producer
        @(negedge clk);
        quiet();
        rs = 5'd6; reg_write_idex = 1'b1; writebackreg_idex = 5'd6; branch_taken = 1'b1;
        #1;
        n_checks++;
        if ({stall, bubble_idex, flush_ifid, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL non_branch: got %b expected 0000", {stall, bubble_idex, flush_ifid, busy});
        end
    endtask

    task automatic test_kill_mid_stall();
        @(negedge clk);
        quiet();
        forwarding = 1'b0;
        branch = 1'b1; branch_taken = 1'b1; rs = 5'd3;
        reg_write_idex = 1'b1; writebackreg_idex = 5'd3;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_pre_stall: got %b expected 1", stall);
        end
        @(negedge clk);
        kill = 1'b1;
        #1;
        n_checks++;
        if ({stall, bubble_idex, flush_ifid, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL kill_cycle: got %b expected 0001", {stall, bubble_idex, flush_ifid, busy});
        end
        // state must be back in idle with nothing pending: a clean branch resolves now
        @(negedge clk);
        quiet();
        branch = 1'b1; branch_taken = 1'b0; rs = 5'd3;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL kill_after: got %b expected 000", {stall, flush_ifid, busy});
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        quiet();
        forwarding = 1'b0;
        branch = 1'b1; branch_taken = 1'b1; rt = 5'd9;
        reg_write_idex = 1'b1; writebackreg_idex = 5'd9;
        @(negedge clk);
        reg_write_idex = 1'b0; writebackreg_idex = 5'd0;
        reg_write_exmem = 1'b1; writebackreg_exmem = 5'd9;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy_before: got %b expected 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        quiet();
        branch = 1'b1; branch_taken = 1'b0; rt = 5'd9;
        #1;
        n_checks++;
        if ({stall, flush_ifid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %b expected 000", {stall, flush_ifid, busy});
        end
    endtask

`ifdef BRANCH_HAZARD_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        quiet();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({stall_cycles, taken_flushes} !== 32'h0) begin
            n_fail++;
            $display("FAIL stats_reset: got %h expected 00000000", {stall_cycles, taken_flushes});
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            quiet();
            forwarding = 1'b0;
            branch = 1'b1; branch_taken = 1'b1; rs = 5'd3;
            reg_write_idex = 1'b1; writebackreg_idex = 5'd3;
            @(negedge clk);
            reg_write_idex = 1'b0; writebackreg_idex = 5'd0;
            reg_write_exmem = 1'b1; writebackreg_exmem = 5'd3;
            @(negedge clk);
            reg_write_exmem = 1'b0; writebackreg_exmem = 5'd0;
            @(negedge clk);
            quiet();
        end
        #1;
        n_checks++;
        if (stall_cycles !== 16'd6) begin
            n_fail++;
            $display("FAIL stats_stall_cycles: got %0d expected 6", stall_cycles);
        end
        n_checks++;
        if (taken_flushes !== 16'd3) begin
            n_fail++;
            $display("FAIL stats_taken_flushes: got %0d expected 3", taken_flushes);
        end
        // continuous D=1 hazard stalls every cycle while staying idle
        @(negedge clk);
        forwarding = 1'b1;
        branch = 1'b1; rs = 5'd4;
        reg_write_idex = 1'b1; writebackreg_idex = 5'd4;
        repeat (70000) @(negedge clk);
        quiet();
        #1;
        n_checks++;
        if (stall_cycles !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_saturate: got %h expected ffff", stall_cycles);
        end
    endtask
`endif

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        forwarding = 1'b1;
        quiet();
        test_reset();
        test_fwd_alu();
        test_fwd_load();
        test_nofwd_d2();
        test_nofwd_exmem();
        test_zero_and_nomatch();
        test_kill_mid_stall();
        test_reset_mid_stall();
`ifdef BRANCH_HAZARD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Stall/flush controller for branches resolved in ID; the counterpart to the branch operand forwarding logic. It detects when a branch's rs/rt producer has not yet reached a forwardable or written-back stage, freezes PC and IF/ID for the required number of cycles, and injects bubbles into ID/EX. Once operands are valid, it flushes IF/ID on a taken branch. It sits in the hazard-control cluster beside the branch forwarding unit and feeds the PC, IF/ID and ID/EX enables.

## Interface
- STALL_W, 2, width of the stall down-counter; must hold the maximum stall depth of 2.
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- forwarding  input  1  1 selects the forwarding stall table, 0 selects the no-forwarding table.
- branch  input  1  instruction in ID is a conditional branch.
- branch_taken  input  1  ID comparator result; meaningful only in the resolve cycle.
- kill  input  1  ID instruction squashed by jump or exception; aborts any pending stall.
- rs, rt  input  5 each  source registers of the ID instruction.
- reg_write_idex, mem_read_idex  input  1 each  ID/EX control bits.
- writebackreg_idex  input  5  ID/EX destination register.
- reg_write_exmem, mem_read_exmem  input  1 each  EX/MEM control bits.
- writebackreg_exmem  input  5  EX/MEM destination register.
- stall  output  1  hold PC and IF/ID.
- bubble_idex  output  1  load a NOP into ID/EX; always equals stall.
- flush_ifid  output  1  replace IF/ID contents with a NOP at the next edge.
- busy  output  1  FSM is in S_STALL.

## Operation
- A match is defined as: reg_write is 1, the destination register is nonzero, and it equals rs, or equals rt when the branch reads rt. rt is always treated as read.
- Required depth D for the current cycle:
  - forwarding=1: a match in ID/EX gives D=1, for both ALU and load producers. After one stall the producer sits in EX/MEM and is forwarded. EX/MEM matches need no stall.
  - forwarding=0: a match in ID/EX gives D=2. A match in EX/MEM only gives D=1. The register file writes in the first half-cycle, so MEM/WB needs no stall.
  - When rs and rt hit different stages, D is the maximum of the per-operand depths.
- FSM states: S_IDLE and S_STALL, with count[STALL_W-1:0].
  - S_IDLE, with branch=1, kill=0 and D>0: assert stall this cycle, load count=D-1, go to S_STALL if D-1>0, otherwise stay.
  - S_IDLE, with branch=1, kill=0 and D=0: this is the resolve cycle. flush_ifid=branch_taken and stall=0.
  - S_STALL: assert stall, decrement count, and suppress hazard re-evaluation. When count reaches 0, return to S_IDLE. The next S_IDLE cycle re-evaluates and must find D=0.
- kill=1 has priority over everything: stall=0, flush_ifid=0, count←0, state←S_IDLE on the next edge.
- branch=0 in S_IDLE means all outputs are 0. Non-branch hazards belong to the load-use unit.
- flush_ifid and stall are never asserted together.

## Timing
- Reset values: state=S_IDLE, count=0, and stall, bubble_idex, flush_ifid and busy all 0.
- Reset asserted mid-stall takes effect at the next edge. The pending stall is discarded.
- stall, bubble_idex and flush_ifid are combinational from the current state and inputs; they take effect at the next clk edge.
- busy is registered and is true exactly while state=S_STALL.
- Total stall cycles for one branch equal D: the detection cycle plus D-1 S_STALL cycles.
- Branch latency from entering ID to resolve is D+1 cycles. A taken branch costs 1 additional flushed fetch.

## Configuration
- BRANCH_HAZARD_STATS_EN defined: adds outputs stall_cycles[15:0] and taken_flushes[15:0].
  - Both are saturating at 16'hFFFF and cleared by reset.
  - stall_cycles increments on every cycle with stall=1.
  - taken_flushes increments on every cycle with flush_ifid=1.
- BRANCH_HAZARD_STATS_EN undefined: these ports and their counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package branch_hazard_pkg holds:
  - the state enum (S_IDLE, S_STALL);
  - constants STALL_FWD_IDEX=1, STALL_NOFWD_IDEX=2, STALL_NOFWD_EXMEM=1.
- One sub-module, sat_counter16 (enable, synchronous clear, saturate), instantiated twice, and only when BRANCH_HAZARD_STATS_EN is defined.

## Test plan
- forwarding=1, ALU writes $5 in ID/EX, branch rs=5: stall=1 for exactly 1 cycle, then resolve. With branch_taken=1, flush_ifid=1 for 1 cycle.
- forwarding=1, lw $7 in ID/EX, branch rt=7: 1 stall. Next cycle EX/MEM holds the load, stall=0, resolve.
- forwarding=0, ALU $3 in ID/EX and $4 in EX/MEM, branch rs=4 rt=3: D=2, stall high for 2 consecutive cycles, busy high in the 2nd.
- Destination $0 in ID/EX matching rs=0: no stall. A branch with no matches resolves immediately, and branch_taken=0 gives flush_ifid=0.
- forwarding=0 with D=2: assert kill in the S_STALL cycle, or assert reset mid-stall. Next cycle stall=0, count=0, busy=0, no flush.
- With BRANCH_HAZARD_STATS_EN: run 3 branches with D=2, each taken. Expect stall_cycles=6 and taken_flushes=3. Force 70000 stall cycles and expect stall_cycles to hold at 16'hFFFF.
